memory_access_bridge: RTL and testbench
=======================================

Name: memory_access_bridge

Overview:
- Parametrised successor of the 32-bit bus-to-memory access unit.
- Bridges a word-addressed peripheral bus (enable/acknowledge handshake) to a synchronous on-chip memory port.
- Generalised over data width, bus and memory address widths, and memory read latency.
- Adds registered byte enables, a release phase (one transfer per enable assertion) and asynchronous reset.

Parameters:
- DATA_W, 32, bus/memory data width in bits; multiple of 8, minimum 8.
- BUS_ADDR_W, 16, width of bus word address.
- MEM_ADDR_W, 32, width of memory byte address; must be >= BUS_ADDR_W + log2(DATA_W/8).
- READ_LATENCY, 2, cycles from address valid to read_data valid; minimum 1.
- MEM_WORDS, 16384, memory depth in words; used only when MEM_ACCESS_BOUNDS_EN is defined.

Ports:
- clk  in  1  system clock, all logic on rising edge.
- reset  in  1  asynchronous, active-high reset.
- bus_address  in  BUS_ADDR_W  word address of the transfer.
- bus_bus_enable  in  1  high while a request is valid.
- bus_byte_enable  in  DATA_W/8  byte lane enables.
- bus_rw  in  1  1 = read, 0 = write.
- bus_write_data  in  DATA_W  write data.
- bus_read_data  out  DATA_W  read data, registered.
- bus_acknowledge  out  1  one-cycle completion pulse.
- bus_irq  out  1  access-error pulse (see Optional Feature).
- address  out  MEM_ADDR_W  memory byte address = {zeros, bus_address, log2(DATA_W/8) zeros}.
- read_data  in  DATA_W  memory read data.
- write_data  out  DATA_W  memory write data.
- byte_en  out  DATA_W/8  memory byte enables, registered.
- wren  out  1  memory write strobe.

Behaviour:
- Reset: all outputs 0; state IDLE; latency counter 0. Reset mid-transfer drops wren and bus_acknowledge immediately. No write completes. The bus must re-issue the request.
- All outputs are registered.
- States: IDLE, READ, WRITE, RELEASE.
- IDLE, at edge E0 with bus_bus_enable=1:
  - Register address, byte_en and write_data from the bus.
  - bus_rw=1: load counter with READ_LATENCY, go to READ.
  - bus_rw=0: go to WRITE.
  - With bus_bus_enable=0, remain in IDLE; address/byte_en/write_data hold their values.
- WRITE, at edge E0+1: wren<=1 and bus_acknowledge<=1; go to RELEASE. Write latency is 1 cycle after sampling. wren is high for exactly one cycle.
- READ:
  - Counter decrements each cycle.
  - At edge E0+READ_LATENCY, bus_read_data<=read_data, bus_acknowledge<=1; go to RELEASE.
  - With READ_LATENCY=1, acknowledge occurs at E0+1.
- RELEASE:
  - wren<=0 and bus_acknowledge<=0 on the first edge.
  - Stay until bus_bus_enable=0, then go to IDLE.
  - A still-asserted enable never retriggers, so a single enable assertion yields exactly one transfer.
  - Enable low on the first RELEASE edge: reach IDLE in one cycle. A new request is accepted from the following edge.
- bus_read_data holds its last value until the next read completes.
- Bus inputs changing after E0 do not affect the transfer in flight (sampled once).
- bus_address is zero-extended; the address never wraps. All-ones bus_address maps to the top word.

Optional Feature:
- Macro: MEM_ACCESS_BOUNDS_EN.
- Defined:
  - At E0 the block compares bus_address against MEM_WORDS.
  - If bus_address >= MEM_WORDS: no wren, no memory wait. At E0+1, bus_acknowledge<=1 and bus_irq<=1 (one cycle). A read returns bus_read_data=0. Then RELEASE as normal.
  - In-range accesses are unaffected.
- Undefined: bus_irq is tied 0, no comparison logic is built, and MEM_WORDS is ignored.

Test Plan:
- Reset asserted mid-WRITE (after E0, before E0+1) -> wren and bus_acknowledge 0 immediately; no write pulse; state IDLE after reset release.
- Write, DATA_W=32, bus_address=0x0010, data 0xA5A5_1234, byte_enable=4'b0011 -> at E0+1 address=0x0000_0040, write_data=0xA5A5_1234, byte_en=4'b0011, wren=1 and ack=1 for one cycle.
- Read, READ_LATENCY=2, memory model returning 0xCAFE_F00D two cycles after address -> ack at E0+2, bus_read_data=0xCAFE_F00D; repeat with READ_LATENCY=1 and 4 -> ack at E0+1 and E0+4.
- bus_bus_enable held high 10 cycles after a write ack -> exactly one wren pulse; next request accepted only after enable drops.
- DATA_W=64, BUS_ADDR_W=12, bus_address=0xFFF -> address=0x0000_7FF8, byte_en width 8.
- MEM_ACCESS_BOUNDS_EN defined, MEM_WORDS=1024:
  - Read at 0x0400 -> ack and bus_irq at E0+1, bus_read_data=0, wren never high.
  - Read at 0x03FF -> normal access, bus_irq=0.

Source files
------------

// File: rtl/memory_access_bridge.sv
// memory_access_bridge: word-addressed enable/acknowledge bus to a synchronous byte-addressed memory port.
// Latency: write strobe and acknowledge 1 cycle after the request is sampled; read acknowledge READ_LATENCY cycles after.
// Backpressure: bus holds enable until acknowledge; one transfer per enable assertion. Optional macro MEM_ACCESS_BOUNDS_EN.
module memory_access_bridge #(
    parameter int DATA_W       = 32,
    parameter int BUS_ADDR_W   = 16,
    parameter int MEM_ADDR_W   = 32,
    parameter int READ_LATENCY = 2,
    parameter int MEM_WORDS    = 16384
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic [BUS_ADDR_W-1:0]   bus_address,
    input  logic                    bus_bus_enable,
    input  logic [DATA_W/8-1:0]     bus_byte_enable,
    input  logic                    bus_rw,
    input  logic [DATA_W-1:0]       bus_write_data,
    output logic [DATA_W-1:0]       bus_read_data,
    output logic                    bus_acknowledge,
    output logic                    bus_irq,
    output logic [MEM_ADDR_W-1:0]   address,
    input  logic [DATA_W-1:0]       read_data,
    output logic [DATA_W-1:0]       write_data,
    output logic [DATA_W/8-1:0]     byte_en,
    output logic                    wren
);

    localparam int BE_W  = DATA_W / 8;
    localparam int OFF_W = $clog2(BE_W);
    localparam int CNT_W = $clog2(READ_LATENCY + 1);

    // Elaboration-time parameter sanity checks.
    if (DATA_W < 8 || (DATA_W % 8) != 0) begin : g_bad_data_w
        $error("DATA_W must be a multiple of 8 and at least 8");
    end
    if (READ_LATENCY < 1) begin : g_bad_latency
        $error("READ_LATENCY must be at least 1");
    end
    if (MEM_ADDR_W < BUS_ADDR_W + OFF_W) begin : g_bad_addr_w
        $error("MEM_ADDR_W too narrow for BUS_ADDR_W plus byte offset");
    end
    if (MEM_WORDS < 1) begin : g_bad_mem_words
        $error("MEM_WORDS must be at least 1");
    end

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_READ    = 2'd1,
        S_WRITE   = 2'd2,
        S_RELEASE = 2'd3
    } state_t;

    state_t                 r_state, w_state_nxt;
    logic [CNT_W-1:0]       r_cnt, w_cnt_nxt;
    logic [MEM_ADDR_W-1:0]  r_address, w_address_nxt;
    logic [DATA_W-1:0]      r_wdata, w_wdata_nxt;
    logic [BE_W-1:0]        r_byte_en, w_byte_en_nxt;
    logic [DATA_W-1:0]      r_rdata, w_rdata_nxt;
    logic                   r_wren, w_wren_nxt;
    logic                   r_ack, w_ack_nxt;
    logic                   r_irq, w_irq_nxt;
    logic                   r_oob, w_oob_nxt;
    logic                   w_oob;

    // Zero-extended word address scaled to a byte address; shift avoids a zero-width concat at DATA_W=8.
    logic [MEM_ADDR_W-1:0]  w_byte_addr;
    assign w_byte_addr = MEM_ADDR_W'(bus_address) << OFF_W;

`ifdef MEM_ACCESS_BOUNDS_EN
    assign w_oob   = 64'(bus_address) >= 64'(MEM_WORDS);
    assign bus_irq = r_irq;
`else
    assign w_oob   = 1'b0;
    assign bus_irq = 1'b0;
`endif

    // State register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) r_state <= S_IDLE;
        else       r_state <= w_state_nxt;
    end

    // Next-state and next-output decode; registered outputs default to holding or clearing.
    always_comb begin
        w_state_nxt   = r_state;
        w_cnt_nxt     = r_cnt;
        w_address_nxt = r_address;
        w_wdata_nxt   = r_wdata;
        w_byte_en_nxt = r_byte_en;
        w_rdata_nxt   = r_rdata;
        w_oob_nxt     = r_oob;
        w_wren_nxt    = 1'b0;
        w_ack_nxt     = 1'b0;
        w_irq_nxt     = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (bus_bus_enable) begin
                    w_address_nxt = w_byte_addr;
                    w_wdata_nxt   = bus_write_data;
                    w_byte_en_nxt = bus_byte_enable;
                    w_oob_nxt     = w_oob;
                    if (bus_rw) begin
                        // Out-of-range reads skip the memory wait and finish next cycle.
                        w_cnt_nxt   = w_oob ? CNT_W'(1) : CNT_W'(READ_LATENCY);
                        w_state_nxt = S_READ;
                    end else begin
                        w_state_nxt = S_WRITE;
                    end
                end
            end
            S_WRITE: begin
                w_wren_nxt  = ~r_oob;
                w_ack_nxt   = 1'b1;
                w_irq_nxt   = r_oob;
                w_state_nxt = S_RELEASE;
            end
            S_READ: begin
                w_cnt_nxt = r_cnt - CNT_W'(1);
                if (r_cnt == CNT_W'(1)) begin
                    w_rdata_nxt = r_oob ? '0 : read_data;
                    w_ack_nxt   = 1'b1;
                    w_irq_nxt   = r_oob;
                    w_state_nxt = S_RELEASE;
                end
            end
            S_RELEASE: begin
                if (!bus_bus_enable) w_state_nxt = S_IDLE;
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // Datapath and output registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_cnt     <= '0;
            r_address <= '0;
            r_wdata   <= '0;
            r_byte_en <= '0;
            r_rdata   <= '0;
            r_wren    <= 1'b0;
            r_ack     <= 1'b0;
            r_irq     <= 1'b0;
            r_oob     <= 1'b0;
        end else begin
            r_cnt     <= w_cnt_nxt;
            r_address <= w_address_nxt;
            r_wdata   <= w_wdata_nxt;
            r_byte_en <= w_byte_en_nxt;
            r_rdata   <= w_rdata_nxt;
            r_wren    <= w_wren_nxt;
            r_ack     <= w_ack_nxt;
            r_irq     <= w_irq_nxt;
            r_oob     <= w_oob_nxt;
        end
    end

    assign address         = r_address;
    assign write_data      = r_wdata;
    assign byte_en         = r_byte_en;
    assign bus_read_data   = r_rdata;
    assign wren            = r_wren;
    assign bus_acknowledge = r_ack;

endmodule

// File: tb/tb_memory_access_bridge.sv
// tb_memory_access_bridge: directed checks of the bridge at read latencies 1, 2, 4 and at 64-bit width.
// Latency: each test steps whole clock cycles; outputs observed 1 time unit after the rising edge.
// Backpressure: bench holds enable per scenario to exercise the release phase.
module tb_memory_access_bridge;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    // Shared 32-bit bus inputs driving three latency variants in lockstep.
    logic [15:0] b_addr;
    logic        b_en;
    logic [3:0]  b_be;
    logic        b_rw;
    logic [31:0] b_wdata;

    logic [31:0] rdata_0, addr_0, wdata_0, mrd_0;
    logic [3:0]  be_0;
    logic        ack_0, irq_0, wren_0;
    logic [31:0] rdata_1, addr_1, wdata_1, mrd_1;
    logic [3:0]  be_1;
    logic        ack_1, irq_1, wren_1;
    logic [31:0] rdata_4, addr_4, wdata_4, mrd_4;
    logic [3:0]  be_4;
    logic        ack_4, irq_4, wren_4;

    // 64-bit variant inputs/outputs.
    logic [11:0] d_addr;
    logic        d_en;
    logic [7:0]  d_be;
    logic        d_rw;
    logic [63:0] d_wdata;
    logic [63:0] x_rdata, x_wdata, x_mrd;
    logic [31:0] x_addr;
    logic [7:0]  x_be;
    logic        x_ack, x_irq, x_wren;

    function automatic logic [31:0] mem_f(input logic [31:0] a);
        return 32'hCAFE_F00D + a;
    endfunction

    // Memory models: data appears READ_LATENCY-1 register stages after the address.
    logic [31:0] m0_s1, m4_s1, m4_s2, m4_s3;
    always @(posedge clk) begin
        m0_s1 <= mem_f(addr_0);
        m4_s1 <= mem_f(addr_4);
        m4_s2 <= m4_s1;
        m4_s3 <= m4_s2;
    end
    assign mrd_0 = m0_s1;
    assign mrd_1 = mem_f(addr_1);
    assign mrd_4 = m4_s3;
    assign x_mrd = {32'h1234_5678, mem_f(x_addr)};

    memory_access_bridge #(.DATA_W(32), .BUS_ADDR_W(16), .MEM_ADDR_W(32), .READ_LATENCY(2), .MEM_WORDS(1024)) u0 (
        .clk(clk), .reset(reset), .bus_address(b_addr), .bus_bus_enable(b_en), .bus_byte_enable(b_be),
        .bus_rw(b_rw), .bus_write_data(b_wdata), .bus_read_data(rdata_0), .bus_acknowledge(ack_0),
        .bus_irq(irq_0), .address(addr_0), .read_data(mrd_0), .write_data(wdata_0), .byte_en(be_0), .wren(wren_0));

    memory_access_bridge #(.DATA_W(32), .BUS_ADDR_W(16), .MEM_ADDR_W(32), .READ_LATENCY(1), .MEM_WORDS(16384)) u1 (
        .clk(clk), .reset(reset), .bus_address(b_addr), .bus_bus_enable(b_en), .bus_byte_enable(b_be),
        .bus_rw(b_rw), .bus_write_data(b_wdata), .bus_read_data(rdata_1), .bus_acknowledge(ack_1),
        .bus_irq(irq_1), .address(addr_1), .read_data(mrd_1), .write_data(wdata_1), .byte_en(be_1), .wren(wren_1));

    memory_access_bridge #(.DATA_W(32), .BUS_ADDR_W(16), .MEM_ADDR_W(32), .READ_LATENCY(4), .MEM_WORDS(16384)) u4 (
        .clk(clk), .reset(reset), .bus_address(b_addr), .bus_bus_enable(b_en), .bus_byte_enable(b_be),
        .bus_rw(b_rw), .bus_write_data(b_wdata), .bus_read_data(rdata_4), .bus_acknowledge(ack_4),
        .bus_irq(irq_4), .address(addr_4), .read_data(mrd_4), .write_data(wdata_4), .byte_en(be_4), .wren(wren_4));

    memory_access_bridge #(.DATA_W(64), .BUS_ADDR_W(12), .MEM_ADDR_W(32), .READ_LATENCY(2), .MEM_WORDS(16384)) u64 (
        .clk(clk), .reset(reset), .bus_address(d_addr), .bus_bus_enable(d_en), .bus_byte_enable(d_be),
        .bus_rw(d_rw), .bus_write_data(d_wdata), .bus_read_data(x_rdata), .bus_acknowledge(x_ack),
        .bus_irq(x_irq), .address(x_addr), .read_data(x_mrd), .write_data(x_wdata), .byte_en(x_be), .wren(x_wren));

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        n_tests++;
        if ({rdata_0, addr_0, wdata_0, be_0, ack_0, irq_0, wren_0} !== 103'd0) begin
            n_fail++;
            $display("FAIL reset_outputs: rdata=%h addr=%h wdata=%h be=%h ack=%b irq=%b wren=%b, all required 0",
                     rdata_0, addr_0, wdata_0, be_0, ack_0, irq_0, wren_0);
        end
        reset = 1'b0;
        step();
        // Request a write, then assert reset between sampling and completion.
        b_addr = 16'h0010; b_wdata = 32'h5555_AAAA; b_be = 4'hF; b_rw = 1'b0; b_en = 1'b1;
        step();                 // E0
        reset = 1'b1;
        #1;
        n_tests++;
        if (wren_0 !== 1'b0 || ack_0 !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_midwrite_immediate: wren=%b ack=%b, required 0 0", wren_0, ack_0);
        end
        for (int k = 0; k < 3; k++) begin
            step();
            n_tests++;
            if (wren_0 !== 1'b0 || ack_0 !== 1'b0 || addr_0 !== 32'h0) begin
                n_fail++;
                $display("FAIL reset_midwrite_cycle%0d: wren=%b ack=%b addr=%h, required 0 0 0", k, wren_0, ack_0, addr_0);
            end
        end
        b_en = 1'b0;
        reset = 1'b0;
        for (int k = 0; k < 3; k++) begin
            step();
            n_tests++;
            if (wren_0 !== 1'b0 || ack_0 !== 1'b0) begin
                n_fail++;
                $display("FAIL reset_release_idle%0d: wren=%b ack=%b, required 0 0", k, wren_0, ack_0);
            end
        end
    endtask

    task automatic test_write();
        b_addr = 16'h0010; b_wdata = 32'hA5A5_1234; b_be = 4'b0011; b_rw = 1'b0; b_en = 1'b1;
        step();                 // E0
        n_tests++;
        if (wren_0 !== 1'b0 || ack_0 !== 1'b0) begin
            n_fail++;
            $display("FAIL write_e0: wren=%b ack=%b, required 0 0", wren_0, ack_0);
        end
        step();                 // E0+1
        n_tests++;
        if (addr_0 !== 32'h0000_0040 || wdata_0 !== 32'hA5A5_1234 || be_0 !== 4'b0011 ||
            wren_0 !== 1'b1 || ack_0 !== 1'b1 || irq_0 !== 1'b0) begin
            n_fail++;
            $display("FAIL write_e1: addr=%h wdata=%h be=%b wren=%b ack=%b irq=%b, required 00000040 a5a51234 0011 1 1 0",
                     addr_0, wdata_0, be_0, wren_0, ack_0, irq_0);
        end
        b_en = 1'b0;
        step();                 // E0+2
        n_tests++;
        if (wren_0 !== 1'b0 || ack_0 !== 1'b0) begin
            n_fail++;
            $display("FAIL write_e2_pulse: wren=%b ack=%b, required 0 0", wren_0, ack_0);
        end
        step();
    endtask

    task automatic test_read_latency();
        logic exp_ack;
        b_addr = 16'h0000; b_rw = 1'b1; b_be = 4'hF; b_en = 1'b1;
        step();                 // E0
        for (int k = 1; k <= 5; k++) begin
            step();             // E0+k
            exp_ack = (k == 2);
            n_tests++;
            if (ack_0 !== exp_ack) begin
                n_fail++;
                $display("FAIL read_lat2_ack_e%0d: ack=%b, required %b", k, ack_0, exp_ack);
            end
            exp_ack = (k == 1);
            n_tests++;
            if (ack_1 !== exp_ack) begin
                n_fail++;
                $display("FAIL read_lat1_ack_e%0d: ack=%b, required %b", k, ack_1, exp_ack);
            end
            exp_ack = (k == 4);
            n_tests++;
            if (ack_4 !== exp_ack) begin
                n_fail++;
                $display("FAIL read_lat4_ack_e%0d: ack=%b, required %b", k, ack_4, exp_ack);
            end
            if (k == 1) begin
                n_tests++;
                if (rdata_1 !== 32'hCAFE_F00D || rdata_0 !== 32'h0) begin
                    n_fail++;
                    $display("FAIL read_data_e1: lat1=%h lat2=%h, required cafef00d 00000000", rdata_1, rdata_0);
                end
            end
            if (k == 2) begin
                n_tests++;
                if (rdata_0 !== 32'hCAFE_F00D || rdata_4 !== 32'h0) begin
                    n_fail++;
                    $display("FAIL read_data_e2: lat2=%h lat4=%h, required cafef00d 00000000", rdata_0, rdata_4);
                end
            end
        end
        n_tests++;
        if (rdata_4 !== 32'hCAFE_F00D || rdata_0 !== 32'hCAFE_F00D || irq_0 !== 1'b0) begin
            n_fail++;
            $display("FAIL read_data_hold: lat4=%h lat2=%h irq=%b, required cafef00d cafef00d 0", rdata_4, rdata_0, irq_0);
        end
        b_en = 1'b0;
        step();
        step();
    endtask

    task automatic test_back_to_back();
        int pulses;
        b_addr = 16'h0020; b_wdata = 32'h1111_2222; b_be = 4'hF; b_rw = 1'b0; b_en = 1'b1;
        step();                 // E0
        step();                 // E0+1
        n_tests++;
        if (wren_0 !== 1'b1 || addr_0 !== 32'h0000_0080) begin
            n_fail++;
            $display("FAIL hold_first_write: wren=%b addr=%h, required 1 00000080", wren_0, addr_0);
        end
        // Enable stays high with new inputs: no further transfer may start.
        b_addr = 16'h0030; b_wdata = 32'hDEAD_BEEF;
        pulses = 0;
        for (int k = 0; k < 10; k++) begin
            step();
            if (wren_0 === 1'b1) pulses++;
        end
        n_tests++;
        if (pulses != 0 || addr_0 !== 32'h0000_0080 || wdata_0 !== 32'h1111_2222) begin
            n_fail++;
            $display("FAIL hold_no_retrigger: extra_pulses=%0d addr=%h wdata=%h, required 0 00000080 11112222",
                     pulses, addr_0, wdata_0);
        end
        b_en = 1'b0;
        step();                 // back to IDLE
        b_en = 1'b1;
        step();                 // E0'
        n_tests++;
        if (wren_0 !== 1'b0) begin
            n_fail++;
            $display("FAIL hold_rearm_e0: wren=%b, required 0", wren_0);
        end
        step();                 // E0'+1
        n_tests++;
        if (wren_0 !== 1'b1 || addr_0 !== 32'h0000_00C0 || wdata_0 !== 32'hDEAD_BEEF) begin
            n_fail++;
            $display("FAIL hold_rearm_write: wren=%b addr=%h wdata=%h, required 1 000000c0 deadbeef", wren_0, addr_0, wdata_0);
        end
        b_en = 1'b0;
        step();
        step();
    endtask

    task automatic test_release_fast();
        b_addr = 16'h0001; b_wdata = 32'h0000_0001; b_be = 4'hF; b_rw = 1'b0; b_en = 1'b1;
        step();                 // E0
        step();                 // E0+1: ack, drop enable at once
        b_en = 1'b0; b_addr = 16'h0005; b_wdata = 32'h0BAD_F00D;
        step();                 // E0+2: RELEASE sees enable low -> IDLE
        b_en = 1'b1;
        step();                 // E0+3: new request sampled
        n_tests++;
        if (wren_0 !== 1'b0 || ack_0 !== 1'b0) begin
            n_fail++;
            $display("FAIL release_fast_e3: wren=%b ack=%b, required 0 0", wren_0, ack_0);
        end
        step();                 // E0+4
        n_tests++;
        if (wren_0 !== 1'b1 || addr_0 !== 32'h0000_0014 || wdata_0 !== 32'h0BAD_F00D) begin
            n_fail++;
            $display("FAIL release_fast_e4: wren=%b addr=%h wdata=%h, required 1 00000014 0badf00d", wren_0, addr_0, wdata_0);
        end
        b_en = 1'b0;
        step();
        step();
    endtask

    task automatic test_wide();
        d_addr = 12'hFFF; d_wdata = 64'h0123_4567_89AB_CDEF; d_be = 8'hF0; d_rw = 1'b0; d_en = 1'b1;
        step();
        step();
        n_tests++;
        if (x_addr !== 32'h0000_7FF8 || x_be !== 8'hF0 || x_wren !== 1'b1 || x_wdata !== 64'h0123_4567_89AB_CDEF) begin
            n_fail++;
            $display("FAIL wide_write: addr=%h be=%h wren=%b wdata=%h, required 00007ff8 f0 1 0123456789abcdef",
                     x_addr, x_be, x_wren, x_wdata);
        end
        d_en = 1'b0;
        step();
        d_rw = 1'b1; d_en = 1'b1;
        step();                 // E0
        step();                 // E0+1
        n_tests++;
        if (x_ack !== 1'b0) begin
            n_fail++;
            $display("FAIL wide_read_e1: ack=%b, required 0", x_ack);
        end
        step();                 // E0+2
        n_tests++;
        if (x_ack !== 1'b1 || x_rdata !== 64'h1234_5678_CAFF_7005) begin
            n_fail++;
            $display("FAIL wide_read_e2: ack=%b rdata=%h, required 1 12345678caff7005", x_ack, x_rdata);
        end
        d_en = 1'b0;
        step();
        step();
    endtask

    task automatic test_bounds();
        b_addr = 16'h0400; b_rw = 1'b1; b_be = 4'hF; b_en = 1'b1;
        step();                 // E0
        step();                 // E0+1
`ifdef MEM_ACCESS_BOUNDS_EN
        n_tests++;
        if (ack_0 !== 1'b1 || irq_0 !== 1'b1 || rdata_0 !== 32'h0 || wren_0 !== 1'b0) begin
            n_fail++;
            $display("FAIL bounds_oob_e1: ack=%b irq=%b rdata=%h wren=%b, required 1 1 00000000 0", ack_0, irq_0, rdata_0, wren_0);
        end
        step();
        n_tests++;
        if (ack_0 !== 1'b0 || irq_0 !== 1'b0 || wren_0 !== 1'b0) begin
            n_fail++;
            $display("FAIL bounds_oob_e2: ack=%b irq=%b wren=%b, required 0 0 0", ack_0, irq_0, wren_0);
        end
`else
        n_tests++;
        if (ack_0 !== 1'b0 || irq_0 !== 1'b0) begin
            n_fail++;
            $display("FAIL nobounds_e1: ack=%b irq=%b, required 0 0", ack_0, irq_0);
        end
        step();
        n_tests++;
        if (ack_0 !== 1'b1 || irq_0 !== 1'b0 || rdata_0 !== 32'hCAFF_000D) begin
            n_fail++;
            $display("FAIL nobounds_e2: ack=%b irq=%b rdata=%h, required 1 0 caff000d", ack_0, irq_0, rdata_0);
        end
`endif
        b_en = 1'b0;
        repeat (5) step();
        b_addr = 16'h03FF; b_en = 1'b1;
        step();                 // E0
        step();                 // E0+1
        n_tests++;
        if (ack_0 !== 1'b0 || irq_0 !== 1'b0) begin
            n_fail++;
            $display("FAIL bounds_inrange_e1: ack=%b irq=%b, required 0 0", ack_0, irq_0);
        end
        step();                 // E0+2
        n_tests++;
        if (ack_0 !== 1'b1 || irq_0 !== 1'b0 || rdata_0 !== 32'hCAFF_0009) begin
            n_fail++;
            $display("FAIL bounds_inrange_e2: ack=%b irq=%b rdata=%h, required 1 0 caff0009", ack_0, irq_0, rdata_0);
        end
        b_en = 1'b0;
        repeat (5) step();
    endtask

    initial begin
        reset = 1'b1;
        b_addr = '0; b_en = 1'b0; b_be = '0; b_rw = 1'b0; b_wdata = '0;
        d_addr = '0; d_en = 1'b0; d_be = '0; d_rw = 1'b0; d_wdata = '0;
        repeat (2) step();
        test_reset();
        test_write();
        test_read_latency();
        test_back_to_back();
        test_release_fast();
        test_wide();
        test_bounds();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
